// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder: FSM states, op codes,
// captured-request payload and the address range check.
package mem_responder_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  typedef struct packed {
    op_t               op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int unsigned       depth);
    return 32'(addr) < depth;
  endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port word storage: synchronous write, registered read whose output
// register holds until the next read enable or a synchronous clear.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic              i_clr,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Output register doubles as the responder's read-data hold register.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts single-cycle RD/WR strobes, waits WAIT extra
// cycles, then completes the access with a one-cycle Ack (and Err on faults).
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WAIT  = 1
) (
  input  logic              i_clk1,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_rd,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_data_in,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_ack,
  output logic              o_busy,
  output logic              o_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  req_t              r_req, w_req_nxt;
  logic              r_ack, w_ack_nxt;
  logic              r_err, w_err_nxt;
  logic              w_we, w_re, w_clr;
  logic              w_in_range;
  logic [DATA_W-1:0] w_rd_data;

  assign w_in_range = addr_in_range(r_req.addr, DEPTH);

  always_ff @(posedge i_clk1) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Captured request only matters while BUSY, so it needs no reset.
  always_ff @(posedge i_clk1) begin
    r_req <= w_req_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req_nxt   = r_req;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_we        = 1'b0;
    w_re        = 1'b0;
    w_clr       = i_reset;
    case (r_state)
      IDLE: begin
        if (i_rd ^ i_wr) begin
          w_req_nxt.op   = i_wr ? OP_WR : OP_RD;
          w_req_nxt.addr = i_addr;
          w_req_nxt.data = i_data_in;
          w_cnt_nxt      = CNT_W'(WAIT);
          w_state_nxt    = BUSY;
        end else if (i_rd && i_wr) begin
          w_err_nxt = 1'b1;
        end
      end
      BUSY: begin
        w_err_nxt = i_rd | i_wr;
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_ack_nxt   = 1'b1;
          w_state_nxt = IDLE;
          // Out-of-range: write dropped, read returns zero; memory untouched on reset.
          if (!w_in_range) begin
            w_err_nxt = 1'b1;
            w_clr     = i_reset || (r_req.op == OP_RD);
          end else if (r_req.op == OP_WR) begin
            w_we = !i_reset;
          end else begin
            w_re = !i_reset;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem_array (
    .i_clk   (i_clk1),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_clr   (w_clr),
    .i_addr  (r_req.addr[AW-1:0]),
    .i_wdata (r_req.data),
    .o_rdata (w_rd_data)
  );

  assign o_data_out = w_rd_data;
  assign o_ack      = r_ack;
  assign o_err      = r_err;
  assign o_busy     = (r_state == BUSY);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT=0,1,3), a directed vector
// table, hand-written corner sequences and random traffic against a model.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int NI    = 3;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst [NI];
  logic        rd  [NI];
  logic        wr  [NI];
  logic [15:0] addr[NI];
  logic [15:0] din [NI];
  logic [15:0] dout[NI];
  logic        ack [NI];
  logic        busy[NI];
  logic        err [NI];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(DEPTH), .WAIT(0)) u_w0 (
    .i_clk1(clk), .i_reset(rst[0]), .i_addr(addr[0]), .i_rd(rd[0]), .i_wr(wr[0]),
    .i_data_in(din[0]), .o_data_out(dout[0]), .o_ack(ack[0]), .o_busy(busy[0]), .o_err(err[0]));
  mem_responder #(.DEPTH(DEPTH), .WAIT(1)) u_w1 (
    .i_clk1(clk), .i_reset(rst[1]), .i_addr(addr[1]), .i_rd(rd[1]), .i_wr(wr[1]),
    .i_data_in(din[1]), .o_data_out(dout[1]), .o_ack(ack[1]), .o_busy(busy[1]), .o_err(err[1]));
  mem_responder #(.DEPTH(DEPTH), .WAIT(3)) u_w3 (
    .i_clk1(clk), .i_reset(rst[2]), .i_addr(addr[2]), .i_rd(rd[2]), .i_wr(wr[2]),
    .i_data_in(din[2]), .o_data_out(dout[2]), .o_ack(ack[2]), .o_busy(busy[2]), .o_err(err[2]));

  function automatic int wait_of(input int k);
    case (k)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  int n_pass  = 0;
  int n_total = 0;
  int edge_no = 0;

  // Reference model: access completes at a computed edge number, memory as array
  bit          m_busy [NI];
  int          m_done [NI];
  bit          m_is_wr[NI];
  logic [15:0] m_addr [NI];
  logic [15:0] m_din  [NI];
  logic [15:0] m_data [NI];
  bit          m_dknown[NI];
  bit          m_ack  [NI];
  bit          m_err  [NI];
  logic [15:0] m_mem  [NI][DEPTH];
  bit          m_known[NI][DEPTH];

  task automatic model_step(input int k);
    m_ack[k] = 1'b0;
    m_err[k] = 1'b0;
    if (rst[k]) begin
      m_busy[k]   = 1'b0;
      m_data[k]   = 16'h0000;
      m_dknown[k] = 1'b1;
    end else if (m_busy[k]) begin
      if (rd[k] || wr[k]) m_err[k] = 1'b1;
      if (edge_no == m_done[k]) begin
        m_ack[k]  = 1'b1;
        m_busy[k] = 1'b0;
        if (int'(m_addr[k]) < DEPTH) begin
          if (m_is_wr[k]) begin
            m_mem[k][m_addr[k][7:0]]   = m_din[k];
            m_known[k][m_addr[k][7:0]] = 1'b1;
          end else begin
            m_data[k]   = m_mem[k][m_addr[k][7:0]];
            m_dknown[k] = m_known[k][m_addr[k][7:0]];
          end
        end else begin
          m_err[k] = 1'b1;
          if (!m_is_wr[k]) begin
            m_data[k]   = 16'h0000;
            m_dknown[k] = 1'b1;
          end
        end
      end
    end else if (rd[k] != wr[k]) begin
      m_busy[k]  = 1'b1;
      m_done[k]  = edge_no + 1 + wait_of(k);
      m_is_wr[k] = wr[k];
      m_addr[k]  = addr[k];
      m_din[k]   = din[k];
    end else if (rd[k] && wr[k]) begin
      m_err[k] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_no++;
    for (int k = 0; k < NI; k++) model_step(k);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", nm, act, exp);
  endtask

  task automatic drive(input int k, input logic r, input logic rd_i, input logic wr_i,
                       input logic [15:0] a, input logic [15:0] d);
    rst[k]  = r;
    rd[k]   = rd_i;
    wr[k]   = wr_i;
    addr[k] = a;
    din[k]  = d;
  endtask

  task automatic chk_out(input string nm, input int k, input logic e_ack, input logic e_busy,
                         input logic e_err, input logic [15:0] e_dout);
    chk($sformatf("%s_ack", nm), 16'(ack[k]), 16'(e_ack));
    chk($sformatf("%s_busy", nm), 16'(busy[k]), 16'(e_busy));
    chk($sformatf("%s_err", nm), 16'(err[k]), 16'(e_err));
    chk($sformatf("%s_dout", nm), dout[k], e_dout);
  endtask

  // One complete access on instance k with expected timing WAIT+1 busy edges
  task automatic access(input string nm, input int k, input bit is_wr, input logic [15:0] a,
                        input logic [15:0] d, input logic e_err, input logic [15:0] e_dout,
                        input logic [15:0] dout_before);
    drive(k, 1'b0, !is_wr, is_wr, a, d);
    tick();
    chk_out($sformatf("%s_acc", nm), k, 1'b0, 1'b1, 1'b0, dout_before);
    drive(k, 1'b0, 1'b0, 1'b0, a, d);
    for (int i = 0; i < wait_of(k); i++) begin
      tick();
      chk_out($sformatf("%s_wait%0d", nm, i), k, 1'b0, 1'b1, 1'b0, dout_before);
    end
    tick();
    chk_out($sformatf("%s_done", nm), k, 1'b1, 1'b0, e_err, e_dout);
  endtask

  typedef struct {
    logic        r, rdv, wrv;
    logic [15:0] a, d;
    logic        e_ack, e_busy, e_err;
    logic [15:0] e_dout;
  } vec_t;

  function automatic vec_t v(input logic r, input logic rdv, input logic wrv, input logic [15:0] a,
                             input logic [15:0] d, input logic e_ack, input logic e_busy,
                             input logic e_err, input logic [15:0] e_dout);
    vec_t t;
    t.r = r; t.rdv = rdv; t.wrv = wrv; t.a = a; t.d = d;
    t.e_ack = e_ack; t.e_busy = e_busy; t.e_err = e_err; t.e_dout = e_dout;
    return t;
  endfunction

  vec_t tv[32];

  initial begin
    //            rst rd wr addr      data      ack busy err dout
    tv[0]  = v(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000);
    tv[1]  = v(0, 0, 1, 16'h0010, 16'hBEEF, 0, 1, 0, 16'h0000);
    tv[2]  = v(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0000);
    tv[3]  = v(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000);
    tv[4]  = v(0, 1, 0, 16'h0010, 16'h0000, 0, 1, 0, 16'h0000);
    tv[5]  = v(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0000);
    tv[6]  = v(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'hBEEF);
    tv[7]  = v(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'hBEEF);
    tv[8]  = v(0, 0, 1, 16'h0000, 16'h5A5A, 0, 1, 0, 16'hBEEF);
    tv[9]  = v(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'hBEEF);
    tv[10] = v(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'hBEEF);
    tv[11] = v(0, 0, 1, 16'h0100, 16'hDEAD, 0, 1, 0, 16'hBEEF);
    tv[12] = v(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'hBEEF);
    tv[13] = v(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'hBEEF);
    tv[14] = v(0, 1, 0, 16'h0100, 16'h0000, 0, 1, 0, 16'hBEEF);
    tv[15] = v(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'hBEEF);
    tv[16] = v(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h0000);
    tv[17] = v(0, 1, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0000);
    tv[18] = v(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0000);
    tv[19] = v(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h5A5A);
    tv[20] = v(0, 1, 1, 16'h0000, 16'h0000, 0, 0, 1, 16'h5A5A);
    tv[21] = v(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h5A5A);
    tv[22] = v(0, 0, 1, 16'h0020, 16'h1111, 0, 1, 0, 16'h5A5A);
    tv[23] = v(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h5A5A);
    tv[24] = v(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h5A5A);
    tv[25] = v(0, 1, 0, 16'h0020, 16'h0000, 0, 1, 0, 16'h5A5A);
    tv[26] = v(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h5A5A);
    tv[27] = v(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h1111);
    tv[28] = v(0, 1, 0, 16'h0010, 16'h0000, 0, 1, 0, 16'h1111);
    tv[29] = v(0, 0, 1, 16'h0030, 16'h7777, 0, 1, 1, 16'h1111);
    tv[30] = v(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'hBEEF);
    tv[31] = v(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'hBEEF);

    for (int k = 0; k < NI; k++) drive(k, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    tick();
    for (int k = 0; k < NI; k++) begin
      chk_out($sformatf("reset_k%0d", k), k, 1'b0, 1'b0, 1'b0, 16'h0000);
      drive(k, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    end

    // Directed table on the WAIT=1 instance
    for (int i = 0; i < 32; i++) begin
      drive(1, tv[i].r, tv[i].rdv, tv[i].wrv, tv[i].a, tv[i].d);
      tick();
      chk_out($sformatf("vec%0d", i), 1, tv[i].e_ack, tv[i].e_busy, tv[i].e_err, tv[i].e_dout);
    end
    drive(1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // WAIT=0: collision in IDLE, then a read with a stray RD in its completion cycle
    access("w0_wr", 0, 1'b1, 16'h0003, 16'h0007, 1'b0, 16'h0000, 16'h0000);
    drive(0, 1'b0, 1'b1, 1'b1, 16'h0003, 16'h0000);
    tick();
    chk_out("w0_both", 0, 1'b0, 1'b0, 1'b1, 16'h0000);
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    chk_out("w0_both_after", 0, 1'b0, 1'b0, 1'b0, 16'h0000);
    drive(0, 1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000);
    tick();
    chk_out("w0_rd_acc", 0, 1'b0, 1'b1, 1'b0, 16'h0000);
    drive(0, 1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000);
    tick();
    chk_out("w0_rd_busyreq", 0, 1'b1, 1'b0, 1'b1, 16'h0007);
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    chk_out("w0_rd_after", 0, 1'b0, 1'b0, 1'b0, 16'h0007);

    // WAIT=3: reset aborts an in-flight write, word keeps its old value
    access("w3_wr", 2, 1'b1, 16'h0005, 16'hAAAA, 1'b0, 16'h0000, 16'h0000);
    access("w3_rd", 2, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'hAAAA, 16'h0000);
    drive(2, 1'b0, 1'b0, 1'b1, 16'h0005, 16'h1234);
    tick();
    chk_out("w3_abort_acc", 2, 1'b0, 1'b1, 1'b0, 16'hAAAA);
    drive(2, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    chk_out("w3_abort_rst", 2, 1'b0, 1'b0, 1'b0, 16'h0000);
    drive(2, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("w3_abort_idle%0d", i), 2, 1'b0, 1'b0, 1'b0, 16'h0000);
    end
    access("w3_rd2", 2, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'hAAAA, 16'h0000);

    // Random traffic on all instances against the model
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < NI; k++) begin
        int unsigned r;
        logic [15:0] a;
        r = $urandom_range(0, 99);
        a = ($urandom_range(0, 9) == 0) ? 16'(256 + $urandom_range(0, 300))
                                         : 16'($urandom_range(0, 15));
        if (r < 2)       drive(k, 1'b1, 1'b0, 1'b0, a, 16'($urandom));
        else if (r < 5)  drive(k, 1'b0, 1'b1, 1'b1, a, 16'($urandom));
        else if (r < 30) drive(k, 1'b0, 1'b1, 1'b0, a, 16'($urandom));
        else if (r < 55) drive(k, 1'b0, 1'b0, 1'b1, a, 16'($urandom));
        else             drive(k, 1'b0, 1'b0, 1'b0, a, 16'($urandom));
      end
      tick();
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("rnd%0d_k%0d_ack", c, k), 16'(ack[k]), 16'(m_ack[k]));
        chk($sformatf("rnd%0d_k%0d_err", c, k), 16'(err[k]), 16'(m_err[k]));
        chk($sformatf("rnd%0d_k%0d_busy", c, k), 16'(busy[k]), 16'(m_busy[k]));
        if (m_dknown[k]) chk($sformatf("rnd%0d_k%0d_dout", c, k), dout[k], m_data[k]);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, number of 16-bit words held (power of two, 2..65536).
REQ-002 Parameter WAIT, default 1, extra wait cycles per access (0..15).
REQ-003 Clk1  input  1  sole clock; all state changes on its rising edge.
REQ-004 Reset  input  1  reset, synchronous, active-high.
REQ-005 Addr  input  16  word address from initiator, sampled with RD/WR.
REQ-006 RD  input  1  read request strobe, single-cycle pulse.
REQ-007 WR  input  1  write request strobe, single-cycle pulse.
REQ-008 DataIn  input  16  write data from initiator, sampled with WR.
REQ-009 DataOut  output  16  read data to initiator, registered, held until next completed read.
REQ-010 Ack  output  1  one-cycle completion pulse for each accepted access.
REQ-011 Busy  output  1  high while an accepted access is in progress.
REQ-012 Err  output  1  one-cycle error pulse (see REQ-020..022).

Function
REQ-013 The block SHALL be a two-state FSM: IDLE, BUSY; Busy SHALL equal (state == BUSY).
REQ-014 In IDLE, an edge with exactly one of RD/WR high SHALL capture Addr, the op and DataIn, load the wait counter with WAIT, and move to BUSY.
REQ-015 In BUSY with counter > 0, each edge SHALL decrement the counter; other state is unchanged.
REQ-016 In BUSY with counter == 0, the edge SHALL complete the access: read sets DataOut to mem[Addr]; write sets mem[Addr] to captured DataIn; Ack is set to 1 for one cycle; state returns to IDLE.
REQ-017 Latency: request sampled at edge T SHALL produce Ack high in the cycle after edge T+1+WAIT; Busy high between edges T and T+1+WAIT.
REQ-018 A request present in the Ack cycle (state IDLE) SHALL be accepted, giving back-to-back throughput of one access per WAIT+2 cycles.
REQ-019 A read of an address written earlier SHALL return the written value; a read completing in the same edge as no write is unaffected by later writes.
REQ-020 RD and WR both high in IDLE: no access, no state change, Err pulses one cycle.
REQ-021 RD or WR high while BUSY: request ignored, in-flight access unaffected, Err pulses one cycle.
REQ-022 Addr >= DEPTH: access accepted and timed normally; read returns 16'h0000, write is dropped; Err pulses in the Ack cycle together with Ack.
REQ-023 Ack and Err SHALL be low in every cycle not specified above; DataOut SHALL change only on read completion or reset.
REQ-024 Memory array SHALL be inferable RAM, one access per edge; contents are undefined at power-up.

Reset
REQ-025 Reset high at an edge SHALL force state IDLE, counter 0, DataOut 16'h0000, Ack 0, Busy 0, Err 0.
REQ-026 Reset during BUSY SHALL abort the access with no Ack and no memory update; memory contents are otherwise preserved.
REQ-027 Reset SHALL take priority over RD/WR on the same edge.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (IDLE, BUSY), the op encoding (OP_RD, OP_WR) and the data-width constant (16).
REQ-029 The storage array SHALL be one sub-module, mem_array (single-port, synchronous write, registered read), instantiated once.

Verification
REQ-030 WAIT=1: WR Addr=16'h0010 DataIn=16'hBEEF at edge T -> Busy edges T..T+2, Ack cycle after T+2, Err 0.
REQ-031 Then RD Addr=16'h0010 -> DataOut=16'hBEEF with Ack, 3 cycles after request; DataOut holds BEEF afterwards.
REQ-032 WAIT=0: RD and WR high together in IDLE -> Err one cycle, Busy stays 0, no Ack; RD during BUSY -> Err, original Ack still at its slot.
REQ-033 DEPTH=256: RD Addr=16'h0100 -> DataOut=16'h0000, Ack and Err together; WR Addr=16'h0100 then RD Addr=16'h0000 -> prior contents of word 0 unchanged.
REQ-034 WAIT=3: WR Addr=5 DataIn=16'h1234, Reset high one cycle after acceptance -> no Ack, Busy 0, DataOut 0; subsequent RD Addr=5 returns the pre-write value.
REQ-035 Back-to-back: WR at T, RD of same address in its Ack cycle -> read Ack WAIT+2 cycles later returning written data.
